timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 109 ++++++++++
 tb/tb_timer_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one N-bit down-counter among four requesters.
// A granted requester owns the counter until it counts out, drops its request, or reset.
module timer_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [N-1:0] len0,
    input  logic [N-1:0] len1,
    input  logic [N-1:0] len2,
    input  logic [N-1:0] len3,
    input  logic         hold,
    output logic [3:0]   gnt,
    output logic [3:0]   done,
    output logic         busy,
    output logic [1:0]   owner,
    output logic [N-1:0] cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state;
    logic [1:0]   ptr;
    logic [1:0]   winner;
    logic [1:0]   idx;
    logic         found;
    logic [N-1:0] win_len;

    // First requester at or after ptr, wrapping round the four slots.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        case (winner)
            2'd0:    win_len = len0;
            2'd1:    win_len = len1;
            2'd2:    win_len = len2;
            default: win_len = len3;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            done  <= 4'b0000;
            owner <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 4'b0000;
                    if (found) begin
                        gnt   <= 4'b0001 << winner;
                        owner <= winner;
                        cnt   <= win_len;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Abort beats hold, hold beats terminal count, terminal beats decrement.
                    if (!req[owner]) begin
                        gnt   <= 4'b0000;
                        done  <= 4'b0000;
                        ptr   <= owner + 2'd1;
                        state <= IDLE;
                    end else if (hold) begin
                        state <= RUN;
                    end else if (cnt == '0) begin
                        done  <= gnt;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - {{(N-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    done  <= 4'b0000;
                    gnt   <= 4'b0000;
                    ptr   <= owner + 2'd1;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= 4'b0000;
                    done  <= 4'b0000;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a job-level model of the arbiter.
module tb_timer_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [7:0] len0 = 8'd0, len1 = 8'd0, len2 = 8'd0, len3 = 8'd0;
    logic       hold = 1'b0;
    logic [3:0] gnt, done;
    logic       busy;
    logic [1:0] owner;
    logic [7:0] cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    timer_arbiter #(.N(8)) dut (
        .clk(clk), .reset(reset), .req(req),
        .len0(len0), .len1(len1), .len2(len2), .len3(len3),
        .hold(hold), .gnt(gnt), .done(done), .busy(busy),
        .owner(owner), .cnt(cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Job-level model: one job may hold the counter; a finished job lingers one cycle.
    int m_ptr = 0, m_owner = 0, m_left = 0;
    bit m_active = 1'b0, m_finish = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ptr = 0; m_owner = 0; m_left = 0; m_active = 0; m_finish = 0;
        end else if (m_finish) begin
            m_finish = 0;
            m_ptr = (m_owner + 1) % 4;
        end else if (m_active) begin
            if (!req[m_owner]) begin
                m_active = 0;
                m_ptr = (m_owner + 1) % 4;
            end else if (!hold) begin
                if (m_left == 0) begin
                    m_active = 0;
                    m_finish = 1;
                end else begin
                    m_left = m_left - 1;
                end
            end
        end else if (req != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                int w;
                w = (m_ptr + k) % 4;
                if (!m_active && req[w]) begin
                    m_owner = w;
                    m_active = 1;
                    case (w)
                        0: m_left = len0;
                        1: m_left = len1;
                        2: m_left = len2;
                        default: m_left = len3;
                    endcase
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [7:0] l0, input logic [7:0] l1,
                                 input logic [7:0] l2, input logic [7:0] l3, input logic h);
        req = r; len0 = l0; len1 = l1; len2 = l2; len3 = l3; hold = h;
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            int eg, ed;
            eg = (m_active || m_finish) ? (1 << m_owner) : 0;
            ed = m_finish ? (1 << m_owner) : 0;
            checkOutput("model_gnt", int'(gnt), eg);
            checkOutput("model_done", int'(done), ed);
            checkOutput("model_busy", int'(busy), int'(m_active || m_finish));
            checkOutput("model_owner", int'(owner), m_owner);
            checkOutput("model_cnt", int'(cnt), m_left);
        end
    end

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitGnt(input logic [3:0] v, input int bound, output int at);
        at = -1;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (gnt == v) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) checkOutput("gnt_timeout", 0, 1);
    endtask

    task automatic waitDone(input logic [3:0] v, input int bound, output int at);
        at = -1;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (done == v) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        int g, d, grants, dones;
        int order[5];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] prevg;

        doReset();
        @(negedge clk);
        checkOutput("reset_gnt", int'(gnt), 0);
        checkOutput("reset_cnt", int'(cnt), 0);
        checkOutput("reset_busy", int'(busy), 0);

        // Single request, len 5: grant next cycle, done six cycles later.
        applyStimulus(4'b0001, 8'd5, 8'd0, 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        checkOutput("single_gnt_next", int'(gnt), 1);
        checkOutput("single_cnt_start", int'(cnt), 5);
        g = cyc;
        waitDone(4'b0001, 20, d);
        checkOutput("single_latency", d - g, 6);
        req = 4'b0000;
        @(negedge clk);
        checkOutput("single_busy_after", int'(busy), 0);

        // Round robin with everyone requesting.
        doReset();
        applyStimulus(4'b1111, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        grants = 0; dones = 0; prevg = 4'b0000;
        for (int n = 0; n < 200 && grants < 5; n++) begin
            @(negedge clk);
            if (done != 4'b0000) dones++;
            if (gnt != 4'b0000 && prevg == 4'b0000) begin
                order[grants] = int'(owner);
                grants++;
            end
            prevg = gnt;
        end
        checkOutput("rr_grants", grants, 5);
        for (int i = 0; i < 5; i++) checkOutput("rr_order", order[i], exp_order[i]);
        checkOutput("rr_dones", dones, 4);

        // Hold for four cycles at cnt 2 stretches the job to eight cycles.
        doReset();
        applyStimulus(4'b0001, 8'd3, 8'd0, 8'd0, 8'd0, 1'b0);
        waitGnt(4'b0001, 10, g);
        @(negedge clk);
        checkOutput("hold_cnt_before", int'(cnt), 2);
        hold = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("hold_cnt_held", int'(cnt), 2);
        hold = 1'b0;
        waitDone(4'b0001, 20, d);
        checkOutput("hold_latency", d - g, 8);
        req = 4'b0000;

        // Abort at cnt 6, then ptr=3 makes requester 0 win over 2.
        doReset();
        applyStimulus(4'b0100, 8'd0, 8'd0, 8'd10, 8'd0, 1'b0);
        waitGnt(4'b0100, 10, g);
        repeat (4) @(negedge clk);
        checkOutput("abort_cnt", int'(cnt), 6);
        req = 4'b0000;
        @(negedge clk);
        checkOutput("abort_gnt", int'(gnt), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        req = 4'b0101;
        @(negedge clk);
        checkOutput("abort_next_owner", int'(owner), 0);
        checkOutput("abort_next_gnt", int'(gnt), 1);
        req = 4'b0000;
        @(negedge clk);

        // Length boundaries.
        doReset();
        applyStimulus(4'b0010, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        waitGnt(4'b0010, 10, g);
        waitDone(4'b0010, 10, d);
        checkOutput("len0_latency", d - g, 1);
        req = 4'b0000;
        @(negedge clk);
        applyStimulus(4'b1000, 8'd0, 8'd0, 8'd0, 8'd255, 1'b0);
        waitGnt(4'b1000, 10, g);
        checkOutput("len255_cnt", int'(cnt), 255);
        waitDone(4'b1000, 400, d);
        checkOutput("len255_latency", d - g, 256);
        req = 4'b0000;
        @(negedge clk);

        // Reset mid-run: finish one job on 2 so ptr=3, then kill a second job on 2.
        doReset();
        applyStimulus(4'b0100, 8'd0, 8'd0, 8'd1, 8'd0, 1'b0);
        waitGnt(4'b0100, 10, g);
        waitDone(4'b0100, 10, d);
        req = 4'b0000;
        @(negedge clk);
        applyStimulus(4'b0100, 8'd0, 8'd0, 8'd9, 8'd0, 1'b0);
        waitGnt(4'b0100, 10, g);
        repeat (5) @(negedge clk);
        checkOutput("rst_mid_cnt", int'(cnt), 4);
        #2 reset = 1'b1;
        req = 4'b1001;
        #1;
        checkOutput("rst_gnt", int'(gnt), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_cnt", int'(cnt), 0);
        checkOutput("rst_owner", int'(owner), 0);
        checkOutput("rst_busy", int'(busy), 0);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_next_owner", int'(owner), 0);
        checkOutput("rst_next_gnt", int'(gnt), 1);
        req = 4'b0000;
        @(negedge clk);

        // Random traffic against the model.
        doReset();
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            hold = ($urandom_range(0, 4) == 0);
            len0 = 8'($urandom_range(0, 6));
            len1 = 8'($urandom_range(0, 6));
            len2 = ($urandom_range(0, 40) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
            len3 = ($urandom_range(0, 10) == 0) ? 8'd0 : 8'($urandom_range(0, 12));
            if ($urandom_range(0, 300) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end
        req = 4'b0000;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
